// File: rtl/m_dram_arbiter.sv
// Three-master DRAM arbiter (MMU > CPU/DMA) with strobe/busy handshake and per-access watchdog.
// Optional macro DRAM_ARB_RR_EN: round-robin between CPU and DMA instead of fixed CPU > DMA.
module m_dram_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  w_req,
  input  logic        w_lock0,
  input  logic [31:0] w_addr0,
  input  logic [31:0] w_addr1,
  input  logic [31:0] w_addr2,
  input  logic        w_we0,
  input  logic        w_we1,
  input  logic        w_we2,
  input  logic [31:0] w_wdata0,
  input  logic [31:0] w_wdata1,
  input  logic [31:0] w_wdata2,
  input  logic [2:0]  w_ctrl0,
  input  logic [2:0]  w_ctrl1,
  input  logic [2:0]  w_ctrl2,
  output logic [2:0]  w_grant,
  output logic [2:0]  w_done,
  output logic        w_err,
  output logic [31:0] w_rdata,
  output logic [31:0] w_dram_addr,
  output logic [31:0] w_dram_wdata,
  output logic [2:0]  w_dram_ctrl,
  output logic        w_dram_le,
  output logic        w_dram_we,
  input  logic        w_dram_busy,
  input  logic [31:0] w_dram_odata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [2:0]     r_grant;
  logic [2:0]     r_done;
  logic           r_err;
  logic [31:0]    r_rdata;
  logic [31:0]    r_dram_addr;
  logic [31:0]    r_dram_wdata;
  logic [2:0]     r_dram_ctrl;
  logic           r_dram_le;
  logic           r_dram_we;
  logic           r_we;
  logic           r_lock;
  logic           r_first;
  logic [TW-1:0]  r_wdog;
`ifdef DRAM_ARB_RR_EN
  logic           r_rr_ptr;  // 0 = CPU preferred, 1 = DMA preferred
`endif

  logic [2:0]     w_pick;
  logic [31:0]    w_sel_addr;
  logic [31:0]    w_sel_wdata;
  logic [2:0]     w_sel_ctrl;
  logic           w_sel_we;

  // Winner selection; a held lock leaves only the MMU eligible.
  always_comb begin
    w_pick = 3'b000;
    if (w_req[0]) begin
      w_pick = 3'b001;
    end else if (!r_lock) begin
`ifdef DRAM_ARB_RR_EN
      if (w_req[1] && w_req[2]) w_pick = r_rr_ptr ? 3'b100 : 3'b010;
      else if (w_req[1])        w_pick = 3'b010;
      else if (w_req[2])        w_pick = 3'b100;
`else
      if (w_req[1])             w_pick = 3'b010;
      else if (w_req[2])        w_pick = 3'b100;
`endif
    end
  end

  always_comb begin
    w_sel_addr  = w_addr0;
    w_sel_wdata = w_wdata0;
    w_sel_ctrl  = w_ctrl0;
    w_sel_we    = w_we0;
    if (w_pick[1]) begin
      w_sel_addr  = w_addr1;
      w_sel_wdata = w_wdata1;
      w_sel_ctrl  = w_ctrl1;
      w_sel_we    = w_we1;
    end else if (w_pick[2]) begin
      w_sel_addr  = w_addr2;
      w_sel_wdata = w_wdata2;
      w_sel_ctrl  = w_ctrl2;
      w_sel_we    = w_we2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_grant      <= 3'b000;
      r_done       <= 3'b000;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_dram_addr  <= 32'd0;
      r_dram_wdata <= 32'd0;
      r_dram_ctrl  <= 3'd0;
      r_dram_le    <= 1'b0;
      r_dram_we    <= 1'b0;
      r_we         <= 1'b0;
      r_lock       <= 1'b0;
      r_first      <= 1'b0;
      r_wdog       <= '0;
`ifdef DRAM_ARB_RR_EN
      r_rr_ptr     <= 1'b0;
`endif
    end else begin
      r_done    <= 3'b000;
      r_err     <= 1'b0;
      r_dram_le <= 1'b0;
      r_dram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick != 3'b000 && !w_dram_busy) begin
            // Strobes are registered here so they are high exactly during ISSUE.
            r_grant      <= w_pick;
            r_we         <= w_sel_we;
            r_dram_addr  <= w_sel_addr;
            r_dram_wdata <= w_sel_wdata;
            r_dram_ctrl  <= w_sel_ctrl;
            r_dram_le    <= !w_sel_we;
            r_dram_we    <= w_sel_we;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_first <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_first <= 1'b0;
          r_wdog  <= r_wdog + 1'b1;
          // busy lags the strobe by one cycle, so the first WAIT cycle is not trusted
          if (!r_first && !w_dram_busy) begin
            if (!r_we) r_rdata <= w_dram_odata;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else if (r_wdog == TW'(TIMEOUT - 1)) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_lock  <= w_lock0 & r_grant[0];
`ifdef DRAM_ARB_RR_EN
          if (r_grant[1] || r_grant[2]) r_rr_ptr <= ~r_rr_ptr;
`endif
          r_grant <= 3'b000;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_grant      = r_grant;
  assign w_done       = r_done;
  assign w_err        = r_err;
  assign w_rdata      = r_rdata;
  assign w_dram_addr  = r_dram_addr;
  assign w_dram_wdata = r_dram_wdata;
  assign w_dram_ctrl  = r_dram_ctrl;
  assign w_dram_le    = r_dram_le;
  assign w_dram_we    = r_dram_we;

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Directed bench for m_dram_arbiter with a small busy-pulse DRAM model; TIMEOUT reduced to 16.
module tb_m_dram_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  w_req = 3'b000;
  logic        w_lock0 = 1'b0;
  logic [31:0] w_addr0 = 32'd0, w_addr1 = 32'd0, w_addr2 = 32'd0;
  logic        w_we0 = 1'b0, w_we1 = 1'b0, w_we2 = 1'b0;
  logic [31:0] w_wdata0 = 32'd0, w_wdata1 = 32'd0, w_wdata2 = 32'd0;
  logic [2:0]  w_ctrl0 = 3'd0, w_ctrl1 = 3'd0, w_ctrl2 = 3'd0;
  logic [2:0]  w_grant, w_done;
  logic        w_err;
  logic [31:0] w_rdata, w_dram_addr, w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_le, w_dram_we;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata = 32'd0;

  int checks = 0;
  int errors = 0;

  // DRAM model: busy rises the cycle after a strobe and lasts busy_len cycles.
  int   busy_len = 0;
  int   bcnt = 0;
  logic force_busy = 1'b0;
  always @(posedge CLK) begin
    if (w_dram_le || w_dram_we) bcnt <= busy_len;
    else if (bcnt > 0)          bcnt <= bcnt - 1;
  end
  assign w_dram_busy = force_busy | (bcnt != 0);

  always #5 CLK = ~CLK;

  m_dram_arbiter #(.TIMEOUT(16), .TW(5)) dut (
    .CLK(CLK), .RST(RST), .w_req(w_req), .w_lock0(w_lock0),
    .w_addr0(w_addr0), .w_addr1(w_addr1), .w_addr2(w_addr2),
    .w_we0(w_we0), .w_we1(w_we1), .w_we2(w_we2),
    .w_wdata0(w_wdata0), .w_wdata1(w_wdata1), .w_wdata2(w_wdata2),
    .w_ctrl0(w_ctrl0), .w_ctrl1(w_ctrl1), .w_ctrl2(w_ctrl2),
    .w_grant(w_grant), .w_done(w_done), .w_err(w_err), .w_rdata(w_rdata),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_le(w_dram_le), .w_dram_we(w_dram_we),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Results of the last access observed by run_access.
  int          a_cyc, a_nle, a_nwe;
  logic [2:0]  a_g, a_dn, a_sc;
  logic [31:0] a_sa, a_sw;
  logic        a_er;

  task automatic run_access(input bit hold_busy);
    a_cyc = 0; a_nle = 0; a_nwe = 0; a_g = 0; a_dn = 0; a_sc = 0; a_sa = 0; a_sw = 0; a_er = 0;
    while (a_cyc < 100) begin
      @(negedge CLK);
      a_cyc++;
      if (hold_busy && a_cyc == 1) force_busy = 1'b1;
      if (w_grant != 3'b000 && a_g == 3'b000) a_g = w_grant;
      if (w_dram_le) a_nle++;
      if (w_dram_we) a_nwe++;
      if (w_dram_le || w_dram_we) begin
        a_sa = w_dram_addr; a_sw = w_dram_wdata; a_sc = w_dram_ctrl;
      end
      if (w_done != 3'b000) begin
        a_dn = w_done; a_er = w_err;
        break;
      end
    end
    $display("access: grant=%b done=%b err=%b cycles=%0d le=%0d we=%0d addr=%h rdata=%h",
             a_g, a_dn, a_er, a_cyc, a_nle, a_nwe, a_sa, w_rdata);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    int bad;
    logic [2:0] exp_g;
    // reset state
    repeat (2) @(negedge CLK);
    check("rst_grant", w_grant, 0);
    check("rst_done", w_done, 0);
    check("rst_err", w_err, 0);
    check("rst_rdata", w_rdata, 0);
    check("rst_strobes", {w_dram_le, w_dram_we}, 0);
    check("rst_addr", w_dram_addr, 0);
    RST = 1'b0;

    // single CPU read with 3 busy cycles
    busy_len = 3; w_dram_odata = 32'hDEADBEEF;
    w_addr1 = 32'h8000_0100; w_we1 = 1'b0; w_ctrl1 = 3'b010; w_req = 3'b010;
    run_access(0);
    check("cpu_rd_cycles", a_cyc, 6);
    check("cpu_rd_done", a_dn, 3'b010);
    check("cpu_rd_le_cnt", a_nle, 1);
    check("cpu_rd_we_cnt", a_nwe, 0);
    check("cpu_rd_addr", a_sa, 32'h8000_0100);
    check("cpu_rd_rdata", w_rdata, 32'hDEADBEEF);
    check("cpu_rd_err", a_er, 0);
    w_req = 3'b000;
    @(negedge CLK);
    check("cpu_rd_done_pulse", w_done, 0);
    check("cpu_rd_grant_clr", w_grant, 0);
    check("cpu_rd_rdata_hold", w_rdata, 32'hDEADBEEF);

    // all three request at once; pointer starts fresh from reset
    do_reset();
    busy_len = 0; w_dram_odata = 32'h0000_0111;
    w_addr0 = 32'h0000_1000; w_addr2 = 32'h0000_3000; w_req = 3'b111;
    run_access(0);
    check("all3_g0", a_g, 3'b001);
    check("all3_d0", a_dn, 3'b001);
    check("all3_cyc0", a_cyc, 4);
    w_req = 3'b110;
    run_access(0);
    check("all3_g1", a_g, 3'b010);
    check("all3_cyc1_b2b", a_cyc, 5);
    w_req = 3'b100;
    run_access(0);
    check("all3_g2", a_g, 3'b100);
    w_req = 3'b000;
    @(negedge CLK);

    // CPU and DMA held continuously
    w_req = 3'b110;
    for (int i = 0; i < 4; i++) begin
`ifdef DRAM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b100;
`else
      exp_g = 3'b010;
`endif
      run_access(0);
      check("cpu_dma_grant", a_g, exp_g);
    end
    w_req = 3'b000;
    @(negedge CLK);

    // MMU locked sequence with CPU requesting throughout
    busy_len = 1; w_lock0 = 1'b1; w_we0 = 1'b0; w_dram_odata = 32'hA5A5_0001;
    w_req = 3'b011;
    run_access(0);
    check("lock_rd1_grant", a_g, 3'b001);
    check("lock_rd1_rdata", w_rdata, 32'hA5A5_0001);
    w_req = 3'b010;
    repeat (2) @(negedge CLK);
    check("lock_hold1_grant", w_grant, 0);
    w_dram_odata = 32'hA5A5_0002; w_req = 3'b011;
    run_access(0);
    check("lock_rd2_grant", a_g, 3'b001);
    check("lock_rd2_cyc", a_cyc, 4);
    w_req = 3'b010;
    repeat (2) @(negedge CLK);
    check("lock_hold2_grant", w_grant, 0);
    w_we0 = 1'b1; w_wdata0 = 32'h0BAD_0000; w_lock0 = 1'b0; w_req = 3'b011;
    run_access(0);
    check("lock_wr_grant", a_g, 3'b001);
    check("lock_wr_we_cnt", a_nwe, 1);
    check("lock_wr_rdata", w_rdata, 32'hA5A5_0002);
    w_req = 3'b010; w_we0 = 1'b0; w_dram_odata = 32'h0000_00CC;
    run_access(0);
    check("lock_release_cpu", a_g, 3'b010);
    check("lock_release_done", a_dn, 3'b010);
    w_req = 3'b000;
    @(negedge CLK);

    // busy high in IDLE blocks the grant
    force_busy = 1'b1; w_req = 3'b010;
    repeat (3) @(negedge CLK);
    check("idle_busy_grant", w_grant, 0);
    force_busy = 1'b0; w_dram_odata = 32'h0000_00DD;
    run_access(0);
    check("idle_busy_cyc", a_cyc, 4);
    check("idle_busy_rdata", w_rdata, 32'h0000_00DD);
    w_req = 3'b000;
    @(negedge CLK);

    // watchdog: busy stuck high from ISSUE on
    w_dram_odata = 32'h1111_1111; w_req = 3'b010;
    run_access(1);
    check("wdog_cycles", a_cyc, 18);
    check("wdog_done", a_dn, 3'b010);
    check("wdog_err", a_er, 1);
    check("wdog_rdata", w_rdata, 32'h0000_00DD);
    w_req = 3'b000; force_busy = 1'b0;
    @(negedge CLK);
    check("wdog_err_pulse", w_err, 0);

    // reset during WAIT of a DMA write
    busy_len = 5;
    w_addr2 = 32'h8020_0000; w_we2 = 1'b1; w_wdata2 = 32'hCAFE_F00D; w_ctrl2 = 3'b001;
    w_req = 3'b100;
    repeat (3) @(negedge CLK);
    check("rst_mid_grant_pre", w_grant, 3'b100);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_grant", w_grant, 0);
    check("rst_mid_addr", w_dram_addr, 0);
    check("rst_mid_wdata", w_dram_wdata, 0);
    check("rst_mid_rdata", w_rdata, 0);
    w_req = 3'b000;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (w_done != 3'b000 || w_dram_le || w_dram_we) bad++;
    end
    check("rst_mid_quiet", bad, 0);
    busy_len = 0; w_dram_odata = 32'h0BAD_CAFE; w_req = 3'b010;
    run_access(0);
    check("rst_after_cyc", a_cyc, 4);
    check("rst_after_done", a_dn, 3'b010);
    check("rst_after_rdata", w_rdata, 32'h0BAD_CAFE);
    w_req = 3'b000;
    @(negedge CLK);

    // DMA write with exact operands
    busy_len = 2; w_dram_odata = 32'hFFFF_FFFF;
    w_addr2 = 32'h8010_0000; w_we2 = 1'b1; w_wdata2 = 32'h1234_5678; w_ctrl2 = 3'b010;
    w_req = 3'b100;
    run_access(0);
    check("dma_wr_cyc", a_cyc, 5);
    check("dma_wr_done", a_dn, 3'b100);
    check("dma_wr_we_cnt", a_nwe, 1);
    check("dma_wr_le_cnt", a_nle, 0);
    check("dma_wr_addr", a_sa, 32'h8010_0000);
    check("dma_wr_wdata", a_sw, 32'h1234_5678);
    check("dma_wr_ctrl", a_sc, 3'b010);
    check("dma_wr_rdata", w_rdata, 32'h0BAD_CAFE);
    w_req = 3'b000;
    @(negedge CLK);
    check("dma_wr_addr_hold", w_dram_addr, 32'h8010_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_dram_arbiter.md
# m_dram_arbiter

Single-port DRAM arbiter that shares the DRAM controller between three masters: the MMU page-table walker (PTE reads and A/D write-backs), the CPU load/store/fetch path, and the DMA engine (disk/NIC buffer moves). It sits between those masters and the DRAM controller port and serializes one access at a time. Each access runs through a strobe/busy handshake, a latched read-data return and a per-access watchdog.

## Interface
Parameters:
- `TIMEOUT`, 4096: maximum cycles in WAIT before the access is aborted.
- `TW`, 13: width of the watchdog counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset. Asynchronous, active-high.
- `w_req[2:0]`  in  3  request per master. Bit 0 = MMU, bit 1 = CPU, bit 2 = DMA.
- `w_lock0`  in  1  MMU bus lock. While high with a grant held, the arbiter returns only to master 0.
- `w_addr0/1/2`  in  32  physical byte address per master.
- `w_we0/1/2`  in  1  write enable per master. 0 = read.
- `w_wdata0/1/2`  in  32  write data per master.
- `w_ctrl0/1/2`  in  3  access size code per master, passed through unchanged.
- `w_grant`  out  3  one-hot: current owner.
- `w_done`  out  3  one-hot, one-cycle completion pulse.
- `w_err`  out  1  one-cycle pulse together with `w_done` when the watchdog fires.
- `w_rdata`  out  32  read data, valid during the `w_done` pulse and held until the next `w_done`.
- `w_dram_addr`  out  32  DRAM address.
- `w_dram_wdata`  out  32  DRAM write data.
- `w_dram_ctrl`  out  3  DRAM size code.
- `w_dram_le`  out  1  DRAM read strobe.
- `w_dram_we`  out  1  DRAM write strobe.
- `w_dram_busy`  in  1  DRAM controller busy.
- `w_dram_odata`  in  32  DRAM read data.

## Operation
- States: IDLE(0), ISSUE(1), WAIT(2), DONE(3), encoded in a 2-bit register.
- IDLE:
  - If `w_req` ≠ 0 and `!w_dram_busy`, select a winner, register it in `w_grant`, latch that master's addr/we/wdata/ctrl into internal registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- Priority:
  - Master 0 always wins when it requests.
  - If `r_lock` is set, only master 0 is eligible. If master 0 is not requesting, the arbiter stays in IDLE.
  - Between masters 1 and 2, selection follows the Configuration section.
- ISSUE:
  - Assert `w_dram_le` (read) or `w_dram_we` (write) for exactly one cycle, with the latched addr/wdata/ctrl.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - The first WAIT cycle is ignored because busy rises one cycle after the strobe.
  - From the second WAIT cycle on, `!w_dram_busy` captures `w_dram_odata` into `w_rdata` (reads only) and goes to DONE.
  - Watchdog counts each WAIT cycle. When count == TIMEOUT-1, go to DONE with the error flag set and leave `w_rdata` unchanged.
- DONE:
  - Pulse `w_done[owner]`, and `w_err` if the error flag is set.
  - Update `r_lock <= w_lock0 & grant[0]`.
  - Clear `w_grant` and go to IDLE.
- Requester rule: hold `w_req` and operands stable from assertion until the `w_done` cycle. `w_req` may drop in the `w_done` cycle and be re-asserted in the next one.
- Outputs to DRAM are driven only from latched registers, never combinationally from requester inputs. `w_dram_addr/wdata/ctrl` hold their last value outside ISSUE.

## Timing
- Reset values: state = IDLE; `w_grant` = 0; `w_done` = 0; `w_err` = 0; `w_rdata` = 0; `w_dram_le` = `w_dram_we` = 0; `w_dram_addr/wdata/ctrl` = 0; `r_lock` = 0; round-robin pointer = CPU; watchdog = 0.
- Minimum latency, from request sampled in IDLE to `w_done`, is 4 cycles: IDLE→ISSUE→WAIT(ignored)→WAIT(busy low)→DONE. Each extra busy cycle adds 1.
- Back-to-back throughput: one access per 5 cycles minimum, because IDLE is revisited between accesses.
- Simultaneous `w_req` = 3'b111 with no lock: grant MMU. Then CPU and DMA are served in the order given by Configuration.
- Reset asserted mid-access: all state returns to reset values immediately. No `w_done` is produced for the aborted access, and no strobe is issued after reset deassertion until a new request is sampled.
- `w_dram_busy` high in IDLE: no grant is made; requests wait.

## Configuration
- `DRAM_ARB_RR_EN` defined:
  - CPU and DMA are round-robin.
  - A 1-bit pointer names the preferred master and flips to the other one in each DONE cycle where the owner was CPU or DMA.
  - MMU grants do not move the pointer.
- `DRAM_ARB_RR_EN` undefined: fixed priority CPU > DMA, and no pointer register exists.

## Test plan
- Single CPU read at 0x8000_0100, busy high for 3 cycles after the strobe, odata = 0xDEADBEEF:
  - `w_dram_le` high for exactly 1 cycle.
  - `w_done` = 3'b010 six cycles after the request.
  - `w_rdata` = 0xDEADBEEF.
- `w_req` = 3'b111 with busy held 0:
  - Grant order MMU, CPU, DMA with the RR macro, and also without it.
  - With RR and CPU+DMA held continuously, grants alternate CPU, DMA, CPU, DMA.
- MMU with `w_lock0` = 1 for two reads plus one write, with CPU requesting throughout:
  - CPU is not granted until after the DONE of the first MMU access with `w_lock0` = 0.
- Busy held high forever, `TIMEOUT` = 16:
  - `w_done` and `w_err` pulse together 17 cycles after ISSUE.
  - `w_rdata` is unchanged.
- `RST` pulsed during WAIT of a DMA write:
  - All outputs return to 0 asynchronously.
  - No `w_done` is produced.
  - The next CPU request completes normally.
- DMA write of 0x1234_5678 to 0x8010_0000 with ctrl = 3'b010:
  - `w_dram_we` pulses once with exact addr/wdata/ctrl.
  - `w_rdata` is unchanged after `w_done`.
